ft245_tx_ctrl: RTL

FT245_TX_CTRL -- requirements
Module: ft245_tx_ctrl

---
 rtl/ft245_tx_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ft245_tx_ctrl.sv
// rtl/ft245_tx_ctrl.sv - FT245 synchronous-FIFO transmit controller
//
// Moves words from a source FIFO (one-cycle read latency) onto the FT245
// write bus through a 2-entry holding buffer, so a byte already requested
// from the FIFO is never lost when the device deasserts TX space.
//
// Optional feature: define FT245_TX_SIWU_EN to build the send-immediate
// (SIWU) FSM. Without it ft_siwu_n is tied high.
//
// Ports:
//   clk          FT245 bus clock, rising edge
//   rst          synchronous active-high reset
//   fifo_empty   source FIFO empty flag
//   fifo_ren     source FIFO read request (combinational)
//   fifo_rdata   source FIFO read data, valid with fifo_rvalid
//   fifo_rvalid  read data valid, one cycle after an accepted fifo_ren
//   ft_txe_n     device TX space available, active-low
//   ft_wr_n      write strobe, active-low
//   ft_data      write data (buffer head)
//   ft_siwu_n    send-immediate strobe, active-low
//   tx_bytes     completed bus transfers, wraps modulo 2^32
//   busy         buffer non-empty or FIFO read in flight

module ft245_tx_ctrl #(
  parameter int DATA_W    = 8,
  parameter int SIWU_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rvalid,
  input  logic              ft_txe_n,
  output logic              ft_wr_n,
  output logic [DATA_W-1:0] ft_data,
  output logic              ft_siwu_n,
  output logic [31:0]       tx_bytes,
  output logic              busy
);

  logic [DATA_W-1:0] r_buf [0:1];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;
  logic              r_ren_q;
  logic [31:0]       r_tx_bytes;

  logic              w_xfer;
  logic              w_push;
  logic              w_busy;
  logic [2:0]        w_inflight;

  assign w_xfer = (r_count != 2'd0) & ~ft_txe_n;
  assign w_push = fifo_rvalid;
  assign w_busy = (r_count != 2'd0) | r_ren_q;

  // Occupancy the buffer will have once the outstanding read lands and this
  // cycle's transfer (if any) leaves; a new read is only safe below 2.
  assign w_inflight = {1'b0, r_count} + {2'b00, r_ren_q} - {2'b00, w_xfer};

  // Strobes are gated with rst so a reset mid-burst never drives a write.
  assign fifo_ren = ~rst & ~fifo_empty & (w_inflight < 3'd2);
  assign ft_wr_n  = ~(w_xfer & ~rst);
  assign ft_data  = r_buf[r_head];
  assign busy     = w_busy & ~rst;
  assign tx_bytes = r_tx_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_ren_q    <= 1'b0;
      r_tx_bytes <= 32'd0;
    end else begin
      r_ren_q <= fifo_ren;
      if (w_push) r_tail <= ~r_tail;
      if (w_xfer) begin
        r_head     <= ~r_head;
        r_tx_bytes <= r_tx_bytes + 32'd1;
      end
      if (w_push && !w_xfer)      r_count <= r_count + 2'd1;
      else if (!w_push && w_xfer) r_count <= r_count - 2'd1;
    end
  end

  // Data storage carries no reset; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_buf[r_tail] <= fifo_rdata;
  end

  always @(posedge clk) begin
    assert (SIWU_IDLE >= 1 && SIWU_IDLE <= 255);
    if (!rst) begin
      assert (!(w_push && !w_xfer && r_count == 2'd2));
      assert (!(fifo_rvalid && !r_ren_q));
    end
  end

`ifdef FT245_TX_SIWU_EN
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT, S_PULSE} siwu_state_t;

  localparam logic [7:0] SIWU_IDLE_8 = SIWU_IDLE[7:0];

  siwu_state_t r_state;
  siwu_state_t w_state_nxt;
  logic [7:0]  r_idle_cnt;

  // Counter is held at 0 outside WAIT, so it is clear on entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT) r_idle_cnt <= r_idle_cnt + 8'd1;
      else                   r_idle_cnt <= 8'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (!w_busy) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_busy)                                w_state_nxt = S_ACTIVE;
        else if (r_idle_cnt + 8'd1 == SIWU_IDLE_8) w_state_nxt = S_PULSE;
      end
      S_PULSE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ft_siwu_n = ~((r_state == S_PULSE) & ~rst);
  end
`else
  assign ft_siwu_n = 1'b1;
`endif

endmodule
